uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory port, decoded alongside ram.
- It is the responder end of the core's data interface: a read-request/address/data path plus a byte-select write path.
- Core writes bytes into an internal FIFO; a serializer shifts them out as 8N1 frames on uart_tx_o.
- Core polls status and sets the baud divisor through the same port.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_periph.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encoding.
package uart_tx_pkg;

  typedef logic [1:0] reg_off_t;

  localparam reg_off_t REG_TXDATA  = 2'd0;
  localparam reg_off_t REG_STATUS  = 2'd1;
  localparam reg_off_t REG_BAUDDIV = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  // A divisor of zero would stall the bit timer, so it behaves as one.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; a pushed entry is readable one
// cycle later (no bypass). Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [31:0] r_addr_i,
  output logic [31:0] r_data_o,
  input  logic [3:0]  wen,
  input  logic [31:0] w_addr_i,
  input  logic [31:0] w_data_i,
  output logic        uart_tx_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_tx_next;
  logic          w_unused;
  logic [7:0]    w_fifo_dout;
  logic [15:0]   w_div_eff;
  logic [31:0]   w_count_ext;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;

  logic [2:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [15:0]   r_cnt;
  logic [15:0]   r_div;
  logic          r_ovf;
  logic          r_tx;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif

  assign w_push      = wen[0] && (w_addr_i[3:2] == REG_TXDATA);
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_div_eff   = eff_div(r_div);
  assign w_bit_end   = (r_cnt <= 16'd1);
  assign w_count_ext = 32'(w_count);
  assign w_unused    = ^{r_addr_i[31:4], r_addr_i[1:0], w_addr_i[31:4],
                         w_addr_i[1:0], w_data_i[31:16]};
  assign r_data_o    = w_rdata;
  assign uart_tx_o   = r_tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_data_i[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Divisor lanes and sticky overflow; a drop on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= 16'(DEFAULT_DIV);
      r_ovf <= 1'b0;
    end else begin
      if (w_addr_i[3:2] == REG_BAUDDIV) begin
        if (wen[0]) r_div[7:0]  <= w_data_i[7:0];
        if (wen[1]) r_div[15:8] <= w_data_i[15:8];
      end
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (wen[0] && (w_addr_i[3:2] == REG_STATUS) && w_data_i[3]) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  // Serializer: the bit timer reloads from the live divisor at every bit start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_cnt     <= 16'd0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_next;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift   <= w_fifo_dout;
            r_bit_idx <= 3'd0;
            r_cnt     <= w_div_eff;
            r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_fifo_dout;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= w_div_eff;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= w_div_eff;
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= w_div_eff;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Line level for the current state, registered one cycle later.
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_parity;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  // STATUS word assembly.
  always_comb begin
    w_status                        = 32'd0;
    w_status[STAT_BUSY]             = (r_state != ST_IDLE);
    w_status[STAT_FULL]             = w_full;
    w_status[STAT_EMPTY]            = w_empty;
    w_status[STAT_OVF]              = r_ovf;
    w_status[STAT_CNT_LSB +: 4]     = w_count_ext[3:0];
  end

  // Zero-wait-state read mux from pre-edge register state.
  always_comb begin
    w_rdata = 32'd0;
    if (ren) begin
      case (r_addr_i[3:2])
        REG_STATUS:  w_rdata = w_status;
        REG_BAUDDIV: w_rdata = {16'd0, r_div};
        default:     w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: frame-level reference model with
// per-cycle line/read checks, directed scenarios and a randomized phase.
module tb_uart_tx_periph;

  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk;
  logic        rst;
  logic        ren;
  logic [31:0] r_addr_i;
  logic [31:0] r_data_o;
  logic [3:0]  wen;
  logic [31:0] w_addr_i;
  logic [31:0] w_data_i;
  logic        uart_tx_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_periph #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (434)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ren       (ren),
    .r_addr_i  (r_addr_i),
    .r_data_o  (r_data_o),
    .wen       (wen),
    .w_addr_i  (w_addr_i),
    .w_data_i  (w_data_i),
    .uart_tx_o (uart_tx_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: whole frames as bit vectors ----------
  logic [7:0]  mq[$];
  logic [15:0] m_div  = 16'd434;
  logic        m_ovf  = 1'b0;
  logic        m_busy = 1'b0;
  logic        exp_tx = 1'b1;
  logic [10:0] m_frame = 11'd0;
  int          m_idx  = 0;
  int          m_left = 0;

  task automatic model_step();
    int         pre_n;
    int         eff;
    logic       drop;
    logic [7:0] b;
    if (rst) begin
      mq.delete();
      m_div  = 16'd434;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      exp_tx = 1'b1;
      m_idx  = 0;
      m_left = 0;
    end else begin
      pre_n  = mq.size();
      eff    = (m_div == 16'd0) ? 1 : int'(m_div);
      drop   = 1'b0;
      exp_tx = m_busy ? m_frame[m_idx] : 1'b1;
      if (m_busy) begin
        if (m_left == 1) begin
          m_idx++;
          if (m_idx == NBITS) m_busy = 1'b0;
          else m_left = eff;
        end else begin
          m_left--;
        end
      end else if (pre_n > 0) begin
        b = mq.pop_front();
        m_frame = {2'b11, b, 1'b0};
`ifdef UART_TX_PARITY_EN
        m_frame[9] = ^b;
`endif
        m_busy = 1'b1;
        m_idx  = 0;
        m_left = eff;
      end
      case (w_addr_i[3:2])
        2'd0: if (wen[0]) begin
          if (pre_n == DEPTH) drop = 1'b1;
          else mq.push_back(w_data_i[7:0]);
        end
        2'd1: if (wen[0] && w_data_i[3]) m_ovf = 1'b0;
        2'd2: begin
          if (wen[0]) m_div[7:0]  = w_data_i[7:0];
          if (wen[1]) m_div[15:8] = w_data_i[15:8];
        end
        default: ;
      endcase
      if (drop) m_ovf = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a[3:2])
      2'd1: begin
        v[0]    = m_busy;
        v[1]    = (mq.size() == DEPTH);
        v[2]    = (mq.size() == 0);
        v[3]    = m_ovf;
        v[11:8] = 4'(mq.size());
      end
      2'd2:    v = {16'd0, m_div};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Line check every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("tx_line", {31'd0, uart_tx_o}, {31'd0, exp_tx});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic re, input logic [31:0] ra,
                       input logic [3:0] we, input logic [31:0] wa,
                       input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    rst = r; ren = re; r_addr_i = ra; wen = we; w_addr_i = wa; w_data_i = wd;
    #1;
    rd = r_data_o;
    if (re) chk("rdata", r_data_o, model_read(ra));
    else    chk("rdata_off", r_data_o, 32'd0);
  endtask

  task automatic idle();
    logic [31:0] d;
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] v);
    logic [31:0] d;
    drive(1'b0, 1'b0, 32'd0, we, a, v, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    drive(1'b0, 1'b1, a, 4'd0, 32'd0, 32'd0, v);
  endtask

  task automatic wait_drained(input string name, input int budget);
    logic [31:0] v;
    logic        done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      rd(32'h4, v);
      if (v == 32'h4) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    logic [9:0]  a5_frame;
    logic        txs[80];
    logic        bsy[80];
    int          f, l, highs, zeros, fb, lb, cnt;

    rst = 1'b1; ren = 1'b0; r_addr_i = 32'd0;
    wen = 4'd0; w_addr_i = 32'd0; w_data_i = 32'd0;
    drive(1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, v);
    drive(1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, v);

    // Reset state
    rd(32'h4, v);  chk("rst_status", v, 32'h0000_0004);
    rd(32'h8, v);  chk("rst_baud", v, 32'd434);
    rd(32'hC, v);  chk("rst_reserved", v, 32'd0);
    chk("rst_tx", {31'd0, uart_tx_o}, 32'd1);

    // 0xA5 at DIV=4: start low two edges after the write, 40-cycle frame
    a5_frame = 10'b1_1010_0101_0;
    wr(32'h8, 4'b0011, 32'd4);
    wr(32'h0, 4'b0001, 32'hA5);
    for (int j = 0; j <= 42; j++) begin
      idle();
      if (j < 2 || j >= 42) chk("a5_wave", {31'd0, uart_tx_o}, 32'd1);
      else chk("a5_wave", {31'd0, uart_tx_o}, {31'd0, a5_frame[(j - 2) / 4]});
    end

    // Fill / overflow / clear at DIV=2 with the serializer busy on byte 0
    wr(32'h8, 4'b0011, 32'd2);
    for (int i = 0; i < 9; i++) wr(32'h0, 4'b0001, 32'h10 + 32'(i));
    rd(32'h4, v);  chk("full_status", v, 32'h0000_0803);
    wr(32'h0, 4'b0001, 32'h99);
    rd(32'h4, v);  chk("ovf_set", v, 32'h0000_080B);
    wr(32'h4, 4'b0001, 32'h8);
    rd(32'h4, v);  chk("ovf_clear", v, 32'h0000_0803);
    wait_drained("drain_fill", 600);

    // Back-to-back frames at DIV=3: one idle cycle between frames
    wr(32'h8, 4'b0011, 32'd3);
    wr(32'h0, 4'b0001, 32'h00);
    wr(32'h0, 4'b0001, 32'h00);
    for (int j = 0; j < 80; j++) begin
      rd(32'h4, v);
      txs[j] = uart_tx_o;
      bsy[j] = v[0];
    end
    f = -1; l = -1; fb = -1; lb = -1;
    for (int j = 0; j < 80; j++) begin
      if (!txs[j]) begin if (f < 0) f = j; l = j; end
      if (bsy[j])  begin if (fb < 0) fb = j; lb = j; end
    end
    highs = 0; zeros = 0;
    for (int j = 0; j < 80; j++) begin
      if (j > f && j < l && txs[j]) highs++;
      if (j > fb && j < lb && !bsy[j]) zeros++;
    end
    chk("b2b_high_gap", 32'(highs), 32'd4);
    chk("b2b_busy_gap", 32'(zeros), 32'd1);
    chk("b2b_span", 32'(l - f + 1), 32'(2 * 3 * (NBITS - 1) + 4));
    wait_drained("drain_b2b", 200);

    // Reset during DATA bit 4 with a second byte queued
    wr(32'h8, 4'b0011, 32'd4);
    wr(32'h0, 4'b0001, 32'h00);
    wr(32'h0, 4'b0001, 32'h00);
    for (int k = 2; k <= 22; k++) idle();
    drive(1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, v);
    chk("pre_rst_low", {31'd0, uart_tx_o}, 32'd0);
    rd(32'h4, v);
    chk("post_rst_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("post_rst_status", v, 32'h0000_0004);
    for (int k = 0; k < 30; k++) begin
      idle();
      chk("post_rst_quiet", {31'd0, uart_tx_o}, 32'd1);
    end
    rd(32'h8, v);  chk("post_rst_baud", v, 32'd434);

    // Frame length for 0x07 at DIV=2 measured by busy cycles
    wr(32'h8, 4'b0011, 32'd2);
    wr(32'h0, 4'b0001, 32'h07);
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      rd(32'h4, v);
      if (v[0]) cnt++;
    end
    chk("frame_len", 32'(cnt), 32'(2 * NBITS));

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic        r;
      logic        re;
      logic [31:0] ra;
      logic [3:0]  we;
      logic [31:0] wa;
      logic [31:0] wd;
      r  = ($urandom_range(0, 299) == 0);
      re = $urandom_range(0, 1) == 1;
      ra = $urandom;
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      wa = $urandom;
      wd = $urandom;
      if (wa[3:2] == 2'd2) wd[15:0] = 16'($urandom_range(0, 4));
      drive(r, re, ra, we, wa, wd, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
